// File: rtl/fir_mac_sequencer.sv
// -----------------------------------------------------------------------------
// fir_mac_sequencer
//
// Time-multiplexed FIR filter controller. A single unsigned multiply-accumulate
// unit evaluates a TAPS-tap FIR, one tap per clock cycle. The block owns the
// circular sample delay line, the runtime-programmable coefficient bank and the
// tap-sequencing state machine.
//
// Ports:
//   clock      - rising-edge clock
//   reset      - asynchronous, active-high reset
//   in_valid   - upstream offers a sample
//   in_ready   - block accepts the offered sample this cycle
//   in_data    - unsigned sample (DATA_W bits)
//   out_valid  - filter result available
//   out_ready  - downstream takes the result
//   out_data   - filter result (OUT_W bits, wide enough never to overflow)
//   cfg_we     - coefficient write strobe
//   cfg_addr   - coefficient index
//   cfg_data   - coefficient value (COEF_W bits)
//   cfg_err    - one-cycle pulse: a coefficient write was dropped while busy
//   busy       - high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module fir_mac_sequencer #(
    parameter int TAPS   = 32,
    parameter int COEF_W = 8,
    parameter int DATA_W = 8,
    parameter int OUT_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    input  logic                     cfg_we,
    input  logic [$clog2(TAPS)-1:0]  cfg_addr,
    input  logic [COEF_W-1:0]        cfg_data,
    output logic                     cfg_err,
    output logic                     busy
);

    localparam int AW   = $clog2(TAPS);
    localparam int PR_W = COEF_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [DATA_W-1:0]   r_line [TAPS];
    logic [COEF_W-1:0]   r_coef [TAPS];
    logic [AW-1:0]       r_wrPtr;
    logic [AW-1:0]       r_base;
    logic [AW-1:0]       r_tap;
    logic [OUT_W-1:0]    r_acc;
    logic                r_cfgErr;

    logic                w_accept;
    logic                w_cfgWrite;
    logic                w_lastTap;
    logic [AW-1:0]       w_rdIdx;
    logic [PR_W-1:0]     w_product;

    // Configuration wins over sample intake, so a sample is only taken in IDLE
    // when no write is being presented. The reset term keeps in_ready low while
    // reset is held, even though the state register already reads IDLE.
    assign w_accept   = (r_state == IDLE) && !cfg_we && in_valid && !reset;
    assign w_cfgWrite = (r_state == IDLE) && cfg_we;

    // TAPS is a power of two, so the natural AW-bit wrap of the subtraction
    // gives the circular read index (base - k) mod TAPS.
    assign w_rdIdx    = r_base - r_tap;
    assign w_lastTap  = (r_tap == AW'(TAPS - 1));
    assign w_product  = r_coef[r_tap] * r_line[w_rdIdx];

    assign out_data   = r_acc;
    assign cfg_err    = r_cfgErr;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy     = 1'b0;
                in_ready = !cfg_we && !reset;
                if (w_accept) begin
                    w_nextState = MAC;
                end
            end
            MAC: begin
                if (w_lastTap) begin
                    w_nextState = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Sample delay line: one write per accepted sample at the circular write
    // pointer; base remembers where the newest sample landed for the MAC walk.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                r_line[i] <= '0;
            end
            r_wrPtr <= '0;
            r_base  <= '0;
        end else if (w_accept) begin
            r_line[r_wrPtr] <= in_data;
            r_base          <= r_wrPtr;
            r_wrPtr         <= r_wrPtr + AW'(1);
        end
    end

    // Coefficient bank: writes only land while idle so a running MAC pass
    // always sees one consistent coefficient set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                r_coef[i] <= '0;
            end
        end else if (w_cfgWrite) begin
            r_coef[cfg_addr] <= cfg_data;
        end
    end

    // A write attempted outside IDLE is discarded and flagged one cycle later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cfgErr <= 1'b0;
        end else begin
            r_cfgErr <= cfg_we && (r_state != IDLE);
        end
    end

    // Tap counter and accumulator. The accumulator is cleared on accept and
    // holds its final sum through OUT so out_data stays stable under
    // backpressure.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tap <= '0;
            r_acc <= '0;
        end else if (w_accept) begin
            r_tap <= '0;
            r_acc <= '0;
        end else if (r_state == MAC) begin
            r_tap <= r_tap + AW'(1);
            r_acc <= r_acc + OUT_W'(w_product);
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fir_mac_sequencer
//
// Directed and randomized bench for fir_mac_sequencer. Expected results come
// from a behavioural model: the full history of accepted samples since reset
// and a copy of the coefficient bank, evaluated as a plain convolution sum.
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_fir_mac_sequencer;

    localparam int TAPS   = 32;
    localparam int COEF_W = 8;
    localparam int DATA_W = 8;
    localparam int OUT_W  = 21;

    logic                clock;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_W-1:0]    out_data;
    logic                cfg_we;
    logic [4:0]          cfg_addr;
    logic [COEF_W-1:0]   cfg_data;
    logic                cfg_err;
    logic                busy;

    int nAsserts = 0;
    int nFails   = 0;

    int unsigned coefM [TAPS];
    int unsigned hist [$];
    int unsigned stim [$];
    longint      gotQ [$];

    fir_mac_sequencer #(
        .TAPS   (TAPS),
        .COEF_W (COEF_W),
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .busy      (busy)
    );

    // Free-running 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: every check funnels through here.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: y = sum over k of coef[k] * x[n-k], with missing history as 0.
    function automatic longint modelY();
        longint s = 0;
        for (int k = 0; k < TAPS; k++) begin
            if (k < hist.size()) begin
                s += longint'(coefM[k]) * longint'(hist[hist.size() - 1 - k]);
            end
        end
        return s;
    endfunction

    function automatic void modelReset();
        for (int k = 0; k < TAPS; k++) coefM[k] = 0;
        hist.delete();
    endfunction

    // All stimulus tasks start and end 1 ns after a rising edge.
    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input bit v, input int unsigned d, input bit rdy);
        in_valid  = v;
        in_data   = DATA_W'(d);
        out_ready = rdy;
    endtask

    // Synchronous-looking reset pulse with checks of the reset-time outputs.
    task automatic doReset(input string tag);
        reset = 1'b1;
        applyStimulus(1'b0, 0, 1'b0);
        cfg_we = 1'b0;
        @(negedge clock);
        checkOutput({tag, "_rst_out_valid"}, out_valid, 0);
        checkOutput({tag, "_rst_out_data"}, out_data, 0);
        checkOutput({tag, "_rst_busy"}, busy, 0);
        checkOutput({tag, "_rst_in_ready"}, in_ready, 0);
        checkOutput({tag, "_rst_cfg_err"}, cfg_err, 0);
        nextCycle();
        reset = 1'b0;
        modelReset();
        @(negedge clock);
        checkOutput({tag, "_post_rst_in_ready"}, in_ready, 1);
        nextCycle();
    endtask

    task automatic programCoef(input int addr, input int unsigned val);
        cfg_we   = 1'b1;
        cfg_addr = 5'(addr);
        cfg_data = COEF_W'(val);
        coefM[addr] = val;
        nextCycle();
        cfg_we = 1'b0;
    endtask

    task automatic acceptOne(input int unsigned x, output longint expY);
        int n = 0;
        in_valid = 1'b1;
        in_data  = DATA_W'(x);
        @(negedge clock);
        while (!in_ready && n < 60) begin
            nextCycle();
            @(negedge clock);
            n++;
        end
        checkOutput("accept_ready", in_ready, 1);
        hist.push_back(x);
        expY = modelY();
        nextCycle();
        in_valid = 1'b0;
    endtask

    task automatic waitResult(input string tag, input longint expY);
        int n = 0;
        @(negedge clock);
        while (!out_valid && n < 60) begin
            nextCycle();
            @(negedge clock);
            n++;
        end
        checkOutput({tag, "_valid"}, out_valid, 1);
        checkOutput(tag, out_data, expY);
        out_ready = 1'b1;
        nextCycle();
        out_ready = 1'b0;
    endtask

    // Streams the samples in stim through the DUT, checking each result in
    // order. Optional timing checks: accept spacing and accept-to-valid latency.
    task automatic runStream(input string tag, input bit randReady, input bit checkTiming);
        longint expQ [$];
        int idx = 0;
        int cyc = 0;
        int firstAccept = -1;
        int lastAccept = -1;
        int firstOut = -1;
        int budget = (stim.size() + 2) * 45 + 100;
        gotQ.delete();
        while ((idx < stim.size() || expQ.size() > 0) && cyc < budget) begin
            applyStimulus(idx < stim.size(), (idx < stim.size()) ? stim[idx] : 0,
                          randReady ? 1'($urandom_range(0, 1)) : 1'b1);
            @(negedge clock);
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput({tag, "_unexpected_out"}, 1, 0);
                end else begin
                    gotQ.push_back(longint'(out_data));
                    checkOutput({tag, "_out"}, out_data, expQ.pop_front());
                end
                if (firstOut < 0) firstOut = cyc;
            end
            if (in_valid && in_ready) begin
                hist.push_back(stim[idx]);
                expQ.push_back(modelY());
                if (checkTiming && lastAccept >= 0) begin
                    checkOutput({tag, "_accept_spacing"}, cyc - lastAccept, TAPS + 2);
                end
                if (firstAccept < 0) firstAccept = cyc;
                lastAccept = cyc;
                idx++;
            end
            nextCycle();
            cyc++;
        end
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput({tag, "_completed"}, (stim.size() - idx) + expQ.size(), 0);
        if (checkTiming) begin
            checkOutput({tag, "_latency"}, firstOut - firstAccept, TAPS + 1);
        end
    endtask

    initial begin
        longint e1;
        longint e2;
        longint held;
        bit sawValid;
        int unsigned a;
        int unsigned d;
        int unsigned x;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        out_ready = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        modelReset();
        #1;

        // Power-on reset and first-cycle in_ready.
        doReset("por");

        // Impulse response with coef[k] = k+1.
        for (int k = 0; k < TAPS; k++) programCoef(k, k + 1);
        @(negedge clock);
        checkOutput("cfg_err_idle_writes", cfg_err, 0);
        nextCycle();
        stim.delete();
        stim.push_back(1);
        for (int i = 0; i < 34; i++) stim.push_back(0);
        runStream("impulse", 1'b0, 1'b1);
        for (int k = 0; k < TAPS; k++) begin
            if (k < gotQ.size()) checkOutput("impulse_tap_value", gotQ[k], k + 1);
        end
        checkOutput("impulse_tail", (gotQ.size() > 33) ? gotQ[33] : -1, 0);

        // Coefficient write during MAC is dropped and flagged.
        x = $urandom_range(1, 255);
        acceptOne(x, e1);
        nextCycle();
        nextCycle();
        cfg_we = 1'b1;
        cfg_addr = 5'd0;
        cfg_data = 8'd99;
        @(negedge clock);
        checkOutput("mac_busy", busy, 1);
        checkOutput("mac_in_ready", in_ready, 0);
        checkOutput("cfg_err_before", cfg_err, 0);
        nextCycle();
        cfg_we = 1'b0;
        @(negedge clock);
        checkOutput("cfg_err_pulse", cfg_err, 1);
        nextCycle();
        @(negedge clock);
        checkOutput("cfg_err_single", cfg_err, 0);
        nextCycle();
        waitResult("dropped_write_result", e1);
        stim.delete();
        stim.push_back(1);
        for (int i = 0; i < 3; i++) stim.push_back(0);
        runStream("reimpulse", 1'b0, 1'b1);

        // Write and sample presented together in IDLE: write first, then accept.
        a = $urandom_range(0, TAPS - 1);
        d = $urandom_range(0, 255);
        x = $urandom_range(0, 255);
        cfg_we = 1'b1;
        cfg_addr = 5'(a);
        cfg_data = 8'(d);
        in_valid = 1'b1;
        in_data = 8'(x);
        @(negedge clock);
        checkOutput("joint_in_ready_blocked", in_ready, 0);
        nextCycle();
        coefM[a] = d;
        cfg_we = 1'b0;
        @(negedge clock);
        checkOutput("joint_in_ready_next", in_ready, 1);
        hist.push_back(x);
        e1 = modelY();
        nextCycle();
        in_valid = 1'b0;
        waitResult("joint_result", e1);

        // Backpressure: result held for 10 cycles while a sample waits.
        acceptOne($urandom_range(0, 255), e1);
        x = $urandom_range(0, 255);
        in_valid = 1'b1;
        in_data = 8'(x);
        for (int n = 0; n < 60; n++) begin
            @(negedge clock);
            if (out_valid) break;
            nextCycle();
        end
        checkOutput("bp_valid", out_valid, 1);
        held = longint'(out_data);
        nextCycle();
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_out_data", out_data, e1);
            checkOutput("bp_stable", out_data, held);
            checkOutput("bp_in_ready", in_ready, 0);
            checkOutput("bp_busy", busy, 1);
            nextCycle();
        end
        out_ready = 1'b1;
        @(negedge clock);
        checkOutput("bp_handshake_data", out_data, e1);
        nextCycle();
        out_ready = 1'b0;
        @(negedge clock);
        checkOutput("bp_pending_accept", in_ready, 1);
        hist.push_back(x);
        e2 = modelY();
        nextCycle();
        in_valid = 1'b0;
        waitResult("bp_pending_result", e2);

        // Randomized coefficients and samples with random backpressure.
        for (int k = 0; k < TAPS; k++) programCoef(k, $urandom_range(0, 255));
        stim.delete();
        for (int i = 0; i < 40; i++) stim.push_back($urandom_range(0, 255));
        runStream("random", 1'b1, 1'b0);

        // Full scale: no overflow in the 21-bit result.
        doReset("fs");
        for (int k = 0; k < TAPS; k++) programCoef(k, 255);
        stim.delete();
        for (int i = 0; i < 32; i++) stim.push_back(255);
        stim.push_back(0);
        runStream("fullscale", 1'b0, 1'b0);
        checkOutput("fullscale_32nd", (gotQ.size() > 31) ? gotQ[31] : -1, 2080800);
        checkOutput("fullscale_33rd", (gotQ.size() > 32) ? gotQ[32] : -1, 2015775);

        // Reset on the 10th MAC cycle; coefficients must come back as zero.
        acceptOne(77, e1);
        repeat (9) nextCycle();
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midmac_rst_out_valid", out_valid, 0);
        checkOutput("midmac_rst_out_data", out_data, 0);
        checkOutput("midmac_rst_busy", busy, 0);
        checkOutput("midmac_rst_in_ready", in_ready, 0);
        nextCycle();
        reset = 1'b0;
        modelReset();
        @(negedge clock);
        checkOutput("midmac_post_in_ready", in_ready, 1);
        sawValid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            nextCycle();
            @(negedge clock);
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("midmac_no_stale_out", sawValid, 0);
        nextCycle();
        acceptOne(5, e1);
        waitResult("cleared_coef_result", e1);
        checkOutput("cleared_coef_zero", e1, 0);

        // Second mid-MAC reset, then reprogram: history must be clean.
        acceptOne(200, e1);
        repeat (9) nextCycle();
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        modelReset();
        for (int k = 0; k < TAPS; k++) programCoef(k, k + 1);
        stim.delete();
        stim.push_back(1);
        for (int i = 0; i < 33; i++) stim.push_back(0);
        runStream("clean_impulse", 1'b0, 1'b1);
        checkOutput("clean_impulse_first", (gotQ.size() > 0) ? gotQ[0] : -1, 1);
        checkOutput("clean_impulse_last", (gotQ.size() > 31) ? gotQ[31] : -1, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
